// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the tinymips MMIO bus controller.
//   state_t  - controller FSM states (IDLE, WAIT, RESP)
//   target_t - decoded access target (RAM, I/O port, unmapped)
//   DEFAULT_IO_BASE - default byte address of ioport0
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_PORT = 2'd1,
        TGT_NONE = 2'd2
    } target_t;

    localparam logic [31:0] DEFAULT_IO_BASE = 32'h0000_2000;

endpackage

// File: rtl/mmio_region_decode.sv
// mmio_region_decode: combinational address decoder.
//   i_addr       - CPU byte address
//   o_target     - TGT_RAM (aligned, below 2^RAM_AWIDTH), TGT_PORT (exact
//                  IO_BASE+4k, k<NUM_PORTS) or TGT_NONE (anything else,
//                  including misaligned addresses)
//   o_port_idx   - port index k, meaningful only when o_target==TGT_PORT
module mmio_region_decode
    import mmio_pkg::*;
#(
    parameter int          NUM_PORTS  = 4,
    parameter int          RAM_AWIDTH = 13,
    parameter logic [31:0] IO_BASE    = DEFAULT_IO_BASE,
    parameter int          PIDX_W     = 2
) (
    input  logic [31:0]       i_addr,
    output target_t           o_target,
    output logic [PIDX_W-1:0] o_port_idx
);

    logic [31:0] w_off;
    logic        w_is_ram;
    logic        w_is_port;

    // Offset into the I/O window; addresses below IO_BASE wrap to huge
    // values and therefore fail the word-index range check.
    assign w_off      = i_addr - IO_BASE;
    assign w_is_ram   = ((i_addr >> RAM_AWIDTH) == 32'd0) && (i_addr[1:0] == 2'b00);
    assign w_is_port  = (w_off[1:0] == 2'b00) && ({2'b00, w_off[31:2]} < 32'(NUM_PORTS));
    assign o_port_idx = w_off[PIDX_W+1:2];

    always_comb begin
        if (w_is_ram)       o_target = TGT_RAM;
        else if (w_is_port) o_target = TGT_PORT;
        else                o_target = TGT_NONE;
    end

endmodule

// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller: bridges the tinymips data-memory port to the data RAM
// and NUM_PORTS I/O ports.
//   i_clk, i_reset                  - clock, async active-high reset
//   i_cpu_req/i_cpu_we/i_cpu_addr   - CPU access (sampled in IDLE only)
//   o_cpu_ready/o_cpu_rdata         - one-cycle completion pulse, read data
//   o_dataram_addr/o_dataram_we     - RAM address (held while waiting), strobe
//   i_dataram_rdata                 - RAM read data
//   o_ioport_we/i_ioport_rdata      - one-hot port strobes, packed port data
//   i_err_clr/o_bus_err/o_err_addr  - sticky unmapped-access error + address
module mmio_bus_controller
    import mmio_pkg::*;
#(
    parameter int          NUM_PORTS  = 4,
    parameter int          RAM_AWIDTH = 13,
    parameter logic [31:0] IO_BASE    = DEFAULT_IO_BASE,
    parameter int          RAM_WAIT   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_cpu_req,
    input  logic                      i_cpu_we,
    input  logic [31:0]               i_cpu_addr,
    output logic                      o_cpu_ready,
    output logic [31:0]               o_cpu_rdata,
    output logic [31:0]               o_dataram_addr,
    output logic                      o_dataram_we,
    input  logic [31:0]               i_dataram_rdata,
    output logic [NUM_PORTS-1:0]      o_ioport_we,
    input  logic [32*NUM_PORTS-1:0]   i_ioport_rdata,
    input  logic                      i_err_clr,
    output logic                      o_bus_err,
    output logic [31:0]               o_err_addr
);

    localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_cnt;
    logic [31:0]         r_addr;
    logic [31:0]         r_rdata;
    logic                r_bus_err;
    logic [31:0]         r_err_addr;
    target_t             w_tgt;
    logic [PIDX_W-1:0]   w_pidx;
    logic                w_accept;
    logic                w_new_err;

    mmio_region_decode #(
        .NUM_PORTS  (NUM_PORTS),
        .RAM_AWIDTH (RAM_AWIDTH),
        .IO_BASE    (IO_BASE),
        .PIDX_W     (PIDX_W)
    ) u_decode (
        .i_addr     (i_cpu_addr),
        .o_target   (w_tgt),
        .o_port_idx (w_pidx)
    );

    assign w_accept  = (r_state == IDLE) && i_cpu_req;
    assign w_new_err = w_accept && (w_tgt == TGT_NONE);

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state and write strobes; strobes only ever leave IDLE with the
    // accepting cycle, so at most one bit is high and only for one cycle.
    always_comb begin
        w_next       = r_state;
        o_dataram_we = 1'b0;
        o_ioport_we  = '0;
        case (r_state)
            IDLE: begin
                if (i_cpu_req) begin
                    if (w_tgt == TGT_RAM && !i_cpu_we) w_next = WAIT;
                    else                               w_next = RESP;
                    o_dataram_we = i_cpu_we && (w_tgt == TGT_RAM);
                    for (int k = 0; k < NUM_PORTS; k++)
                        o_ioport_we[k] = i_cpu_we && (w_tgt == TGT_PORT) &&
                                         (w_pidx == PIDX_W'(k));
                end
            end
            WAIT:    if (r_cnt == 3'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Captured address, wait counter and read-data register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cpu_req) begin
                        r_addr <= i_cpu_addr;
                        if (!i_cpu_we) begin
                            case (w_tgt)
                                TGT_RAM:  r_cnt   <= 3'(RAM_WAIT - 1);
                                TGT_PORT: r_rdata <= i_ioport_rdata[32*w_pidx +: 32];
                                default:  r_rdata <= '0;
                            endcase
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'd0) r_rdata <= i_dataram_rdata;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Sticky error: a new fault only records its address when no fault is
    // pending, or when it coincides with a clear (the fault wins).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end else if (w_new_err && (!r_bus_err || i_err_clr)) begin
            r_bus_err  <= 1'b1;
            r_err_addr <= i_cpu_addr;
        end else if (i_err_clr && !w_new_err) begin
            r_bus_err  <= 1'b0;
        end
    end

    assign o_cpu_ready    = (r_state == RESP);
    assign o_cpu_rdata    = r_rdata;
    assign o_dataram_addr = (r_state == IDLE) ? i_cpu_addr : r_addr;
    assign o_bus_err      = r_bus_err;
    assign o_err_addr     = r_err_addr;

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Scoreboard bench for mmio_bus_controller (NUM_PORTS=4, RAM_WAIT=3).
// The driver issues directed and random accesses and pushes the expected
// completion cycle and read data; an independent monitor pops on cpu_ready.
module tb_mmio_bus_controller;

    localparam int          NP  = 4;
    localparam int          RW  = 3;
    localparam logic [31:0] IOB = 32'h0000_2000;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_req, cpu_we, err_clr;
    logic [31:0]     cpu_addr;
    logic            cpu_ready, dataram_we, bus_err;
    logic [31:0]     cpu_rdata, dataram_addr, dataram_rdata, err_addr;
    logic [NP-1:0]   ioport_we;
    logic [32*NP-1:0] ioport_rdata;

    always #5 clk = ~clk;

    mmio_bus_controller #(
        .NUM_PORTS(NP), .RAM_AWIDTH(13), .IO_BASE(IOB), .RAM_WAIT(RW)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .o_cpu_ready(cpu_ready), .o_cpu_rdata(cpu_rdata),
        .o_dataram_addr(dataram_addr), .o_dataram_we(dataram_we),
        .i_dataram_rdata(dataram_rdata),
        .o_ioport_we(ioport_we), .i_ioport_rdata(ioport_rdata),
        .i_err_clr(err_clr), .o_bus_err(bus_err), .o_err_addr(err_addr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    logic        m_err   = 1'b0;
    logic [31:0] m_eaddr = 32'h0;

    // RAM contents are a fixed function of address; the RAM answers RW
    // cycles after it sees an address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hCAFE_F00D;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    logic [31:0] rpipe [RW];
    always @(posedge clk) begin
        rpipe[0] <= mem_word(dataram_addr);
        for (int i = 1; i < RW; i++) rpipe[i] <= rpipe[i-1];
    end
    assign dataram_rdata = rpipe[RW-1];

    // 0 = unmapped, 1 = RAM, 2+k = port k
    function automatic int tgt_of(input logic [31:0] a);
        if (a < 32'd8192 && a % 4 == 0) return 1;
        for (int k = 0; k < NP; k++) if (a == IOB + 32'(4 * k)) return 2 + k;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic rand_ports();
        ioport_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic clr);
        int          t;
        logic [NP-1:0] exp_iowe;
        exp_t        e;
        bit          done;
        @(negedge clk);
        rand_ports();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; err_clr = clr;
        t = tgt_of(a);
        exp_iowe = '0;
        if (we && t >= 2) exp_iowe[t-2] = 1'b1;
        #1;
        check("dataram_we_accept", 32'(dataram_we), 32'(we && t == 1));
        check("ioport_we_accept", 32'(ioport_we), 32'(exp_iowe));
        check("dataram_addr_idle", dataram_addr, a);
        e.rd  = !we;
        e.cyc = cyc + ((!we && t == 1) ? RW + 1 : 1);
        if (t == 0)      e.data = 32'h0;
        else if (t == 1) e.data = mem_word(a);
        else             e.data = ioport_rdata[32*(t-2) +: 32];
        sbq.push_back(e);
        if (t == 0 && (!m_err || clr)) begin
            m_err = 1'b1; m_eaddr = a;
        end else if (t != 0 && clr) begin
            m_err = 1'b0;
        end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
            // Requests outside IDLE must be ignored
            cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom;
            err_clr = 1'b0;
            rand_ports();
            #1;
            check("dataram_we_busy", 32'(dataram_we), 32'h0);
            check("ioport_we_busy", 32'(ioport_we), 32'h0);
            check("dataram_addr_hold", dataram_addr, a);
        end
        if (!done) check("ready_timeout", 32'(done), 32'h1);
        check("bus_err", 32'(bus_err), 32'(m_err));
        check("err_addr", err_addr, m_eaddr);
        cpu_req = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && cpu_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", 32'(cpu_ready), 32'h0);
            end else begin
                e = sbq.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                if (e.rd) check("cpu_rdata", cpu_rdata, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; err_clr = 1'b0;
        ioport_rdata = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(cpu_ready), 32'h0);
        check("reset_rdata", cpu_rdata, 32'h0);
        check("reset_bus_err", 32'(bus_err), 32'h0);
        check("reset_err_addr", err_addr, 32'h0);
        check("reset_dataram_we", 32'(dataram_we), 32'h0);
        check("reset_ioport_we", 32'(ioport_we), 32'h0);

        // Directed cases
        access(1'b1, 32'h0000_0040, 1'b0);
        access(1'b1, 32'h0000_2008, 1'b0);
        access(1'b0, 32'h0000_0100, 1'b0);
        @(negedge clk); #1;
        check("rdata_hold_ready_low", 32'(cpu_ready), 32'h0);
        check("rdata_hold", cpu_rdata, 32'hCAFE_F00D);
        access(1'b0, 32'h0000_2010, 1'b0);
        access(1'b0, 32'h0000_2011, 1'b0);
        check("first_err_addr", err_addr, 32'h0000_2010);
        access(1'b1, 32'h0000_4000, 1'b1);
        check("err_beats_clr", err_addr, 32'h0000_4000);
        access(1'b0, 32'h0000_200C, 1'b0);
        access(1'b0, 32'h0000_1FFC, 1'b1);
        check("err_cleared", 32'(bus_err), 32'h0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = {19'b0, 11'($urandom_range(0, 2047)), 2'b00};
                2:       a = IOB + 32'(4 * $urandom_range(0, NP - 1));
                3:       a = IOB + 32'($urandom_range(0, 31));
                4:       a = 32'($urandom_range(0, 8191));
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            access(1'($urandom), a, ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a RAM read
        access(1'b1, 32'h0000_4000, 1'b0);
        access(1'b0, 32'h0000_0100, 1'b0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200; err_clr = 1'b0;
        #1;
        check("abort_accept_we", 32'(dataram_we), 32'h0);
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = 32'h0000_0300;
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(cpu_ready), 32'h0);
        check("abort_rdata", cpu_rdata, 32'h0);
        check("abort_bus_err", 32'(bus_err), 32'h0);
        check("abort_err_addr", err_addr, 32'h0);
        check("abort_idle_addr", dataram_addr, 32'h0000_0300);
        m_err = 1'b0; m_eaddr = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("abort_no_ready", 32'(cpu_ready), 32'h0);
        end
        access(1'b0, 32'h0000_2004, 1'b0);
        access(1'b0, 32'h0000_0100, 1'b0);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) check("scoreboard_drain", 32'(sbq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bus_controller.md
# mmio_bus_controller

Parametrised memory-mapped bus controller between the tinymips data-memory port and its targets: data RAM plus `NUM_PORTS` I/O ports. Decodes each CPU access, issues single-cycle write strobes, sequences wait states for the synchronous RAM, registers read data, and returns a one-cycle `cpu_ready` per access. Unmapped accesses are absorbed: writes are dropped, reads return 0, and a sticky bus error with the faulting address is recorded.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of I/O ports, 1..16
- `RAM_AWIDTH`, 13, RAM region is byte addresses 0 .. 2^RAM_AWIDTH-1
- `IO_BASE`, 32'h0000_2000, byte address of ioport0; port k at `IO_BASE + 4*k`
- `RAM_WAIT`, 1, RAM read latency in cycles, 1..7

Ports:
- `clk` in 1 — system clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `cpu_req` in 1 — access request, sampled in IDLE only
- `cpu_we` in 1 — 1 write, 0 read
- `cpu_addr` in 32 — byte address
- `cpu_ready` out 1 — one-cycle completion pulse
- `cpu_rdata` out 32 — read data, valid while `cpu_ready`=1
- `dataram_addr` out 32 — RAM address (held during wait)
- `dataram_we` out 1 — RAM write strobe
- `dataram_rdata` in 32 — RAM read data
- `ioport_we` out NUM_PORTS — one-hot I/O write strobes
- `ioport_rdata` in 32*NUM_PORTS — port k data at bits [32k+31:32k]
- `err_clr` in 1 — clears `bus_err`
- `bus_err` out 1 — sticky unmapped-access flag
- `err_addr` out 32 — address of first unmapped access since clear

## Operation
- Decode (on `cpu_addr`, in IDLE): RAM if `cpu_addr < 2^RAM_AWIDTH` and `[1:0]`=0; PORT k if `cpu_addr == IO_BASE+4k`, k<NUM_PORTS; else UNMAPPED (includes misaligned).
- FSM states: IDLE, WAIT, RESP.
- IDLE & `cpu_req`: capture `we`, addr, target. Write RAM: `dataram_we`=1 this cycle -> RESP. Write PORT k: `ioport_we[k]`=1 this cycle -> RESP. Read PORT k: register `ioport_rdata` slice -> RESP. Read RAM: load counter to RAM_WAIT-1 -> WAIT (RAM_WAIT=1 means WAIT lasts one cycle). UNMAPPED: no strobe, rdata 0, error logic -> RESP.
- WAIT: `dataram_addr` = captured addr; when counter is 0, register `dataram_rdata` -> RESP; else decrement.
- RESP: `cpu_ready`=1 for exactly one cycle -> IDLE. `cpu_req` ignored in WAIT and RESP.
- `dataram_addr` = `cpu_addr` in IDLE, captured addr otherwise.
- Strobes are combinational from IDLE state and inputs; never asserted outside IDLE, never more than one bit set.
- Error: UNMAPPED access while `bus_err`=0 sets `bus_err` and loads `err_addr`; while `bus_err`=1 `err_addr` holds. `err_clr` clears `bus_err` (err_addr retained). New error and `err_clr` in the same cycle: error wins, `err_addr` reloads.

## Timing
- Reset values: state IDLE, `cpu_ready` 0, `cpu_rdata` 0, `bus_err` 0, `err_addr` 0, counter 0; strobes 0.
- Accept at cycle T. Writes, I/O reads, and unmapped accesses: `cpu_ready` at T+1. RAM read: `cpu_ready` at T+RAM_WAIT+1.
- Max throughput: one access per 2 cycles.
- `cpu_rdata` holds its last value after `cpu_ready` drops.
- Reset mid-access: abort immediately, no ready pulse, outputs to reset values.

## Structure
- Package `mmio_pkg`: state enum (IDLE, WAIT, RESP), target enum (TGT_RAM, TGT_PORT, TGT_NONE), default IO_BASE constant.
- Sub-module `mmio_region_decode`: combinational; addr -> target and port index.

## Test plan
- Reset, then write 0x1234 to 0x0000_0040 -> `dataram_we`=1 at T, `cpu_ready` at T+1, no `ioport_we`.
- Write to 0x0000_2008 (NUM_PORTS=4) -> `ioport_we`=4'b0100 for one cycle, ready at T+1.
- RAM_WAIT=3, read 0x0000_0100 with RAM returning 0xCAFE_F00D -> `dataram_addr` held 0x100 through WAIT, ready at T+4, `cpu_rdata`=0xCAFE_F00D.
- Read 0x0000_2010 (NUM_PORTS=4), then 0x0000_2011 -> rdata 0 both times, `bus_err`=1, `err_addr`=0x0000_2010 (first only).
- `err_clr` asserted in the same cycle as an unmapped write to 0x0000_4000 -> `bus_err` stays 1, `err_addr`=0x0000_4000.
- `reset` during WAIT of a RAM read -> no `cpu_ready`, state IDLE, all outputs at reset values next cycle.
